// File: rtl/chr_gen_pkg.sv
// chr_gen_pkg: shared default widths and fill-level thresholds for the FIFO family
package chr_gen_pkg;
  localparam int C_DEF_DAT_W = 8;
  localparam int C_DEF_ADR_W = 4;
  localparam int C_DEF_AE_LVL = 2;
  function automatic int af_lvl(input int adr_w);
    return (1 << adr_w) - 2;
  endfunction
endpackage

// File: rtl/sfifo_mem.sv
// sfifo_mem: simple dual-port storage, one write port and one registered read port
module sfifo_mem import chr_gen_pkg::*; #(
  parameter int C_DAT_W = C_DEF_DAT_W,
  parameter int C_ADR_W = C_DEF_ADR_W
) (
  input  logic               CK_i,
  input  logic               WE_i,
  input  logic [C_ADR_W-1:0] WA_i,
  input  logic [C_DAT_W-1:0] WD_i,
  input  logic               RE_i,
  input  logic [C_ADR_W-1:0] RA_i,
  output logic [C_DAT_W-1:0] RD_o
);
  logic [C_DAT_W-1:0] mem_q [2**C_ADR_W];
  logic [C_DAT_W-1:0] rdat_q;
  // unreset array and enabled output register so the tools map this to block RAM
  always_ff @(posedge CK_i) begin
    if (WE_i) mem_q[WA_i] <= WD_i;
    if (RE_i) rdat_q <= mem_q[RA_i];
  end
  assign RD_o = rdat_q;
endmodule

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock FIFO with occupancy count, level flags and sticky error flags
module sc_fifo import chr_gen_pkg::*; #(
  parameter int C_DAT_W  = C_DEF_DAT_W,
  parameter int C_ADR_W  = C_DEF_ADR_W,
  parameter int C_AF_LVL = af_lvl(C_ADR_W),
  parameter int C_AE_LVL = C_DEF_AE_LVL
) (
  input  logic               CK_i,
  input  logic               XAR_i,
  input  logic               CLR_i,
  input  logic               WE_i,
  input  logic [C_DAT_W-1:0] WDs_i,
  input  logic               RE_i,
  output logic [C_DAT_W-1:0] RDs_o,
  output logic               RVLD_o,
  output logic               FULL_o,
  output logic               EMPTY_o,
  output logic               AFULL_o,
  output logic               AEMPTY_o,
  output logic [C_ADR_W:0]   CNTs_o,
  output logic               OVF_o,
  output logic               UDF_o
);
  localparam logic [C_ADR_W:0] DEPTH = (C_ADR_W+1)'(2**C_ADR_W);
  localparam logic [C_ADR_W:0] AF = (C_ADR_W+1)'(C_AF_LVL);
  localparam logic [C_ADR_W:0] AE = (C_ADR_W+1)'(C_AE_LVL);
  logic [C_ADR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [C_ADR_W:0]   cnt_q, cnt_d;
  logic               rvld_q, rvld_d, ovf_q, ovf_d, udf_q, udf_d, seen_q, seen_d;
  logic               wr_acc, rd_acc;
  logic [C_DAT_W-1:0] mem_rd;
  // accept decisions and next state; flush wins over both requests
  always_comb begin
    wr_acc = WE_i & ~FULL_o & ~CLR_i;
    rd_acc = RE_i & ~EMPTY_o & ~CLR_i;
    wptr_d = CLR_i ? '0 : wptr_q + C_ADR_W'(wr_acc);
    rptr_d = CLR_i ? '0 : rptr_q + C_ADR_W'(rd_acc);
    cnt_d  = CLR_i ? '0 : cnt_q + (C_ADR_W+1)'(wr_acc) - (C_ADR_W+1)'(rd_acc);
    rvld_d = rd_acc;
    ovf_d  = ~CLR_i & (ovf_q | (WE_i & FULL_o));
    udf_d  = ~CLR_i & (udf_q | (RE_i & EMPTY_o));
    seen_d = seen_q | rd_acc;
  end
  // control state; seen_q masks the unreset RAM output until the first read after reset
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rvld_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rvld_q <= rvld_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      seen_q <= seen_d;
    end
  end
  sfifo_mem #(.C_DAT_W(C_DAT_W), .C_ADR_W(C_ADR_W)) u_mem (
    .CK_i(CK_i),
    .WE_i(wr_acc),
    .WA_i(wptr_q),
    .WD_i(WDs_i),
    .RE_i(rd_acc),
    .RA_i(rptr_q),
    .RD_o(mem_rd)
  );
  assign RDs_o    = seen_q ? mem_rd : '0;
  assign RVLD_o   = rvld_q;
  assign CNTs_o   = cnt_q;
  assign FULL_o   = cnt_q == DEPTH;
  assign EMPTY_o  = cnt_q == '0;
  assign AFULL_o  = cnt_q >= AF;
  assign AEMPTY_o = cnt_q <= AE;
  assign OVF_o    = ovf_q;
  assign UDF_o    = udf_q;
endmodule

// File: tb/tb_sc_fifo.sv
// tb_sc_fifo: queue-model scoreboard plus directed checks for sc_fifo
module tb_sc_fifo;
  logic       ck = 1'b0, xar = 1'b1, clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0] wd = 8'h00;
  logic [7:0] rd;
  logic       rvld, full, empty, afull, aempty, ovf, udf;
  logic [4:0] cnt;
  int         n_chk = 0, n_fail = 0;
  bit         chk_on = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] m_rd = 8'h00;
  bit         m_rvld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  sc_fifo dut (
    .CK_i(ck), .XAR_i(xar), .CLR_i(clr), .WE_i(we), .WDs_i(wd), .RE_i(re),
    .RDs_o(rd), .RVLD_o(rvld), .FULL_o(full), .EMPTY_o(empty), .AFULL_o(afull),
    .AEMPTY_o(aempty), .CNTs_o(cnt), .OVF_o(ovf), .UDF_o(udf)
  );

  initial forever #5 ck = ~ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a queue of accepted words, decisions taken from pre-edge occupancy
  initial forever begin
    @(posedge ck or negedge xar);
    if (!xar) begin
      m_q.delete(); m_rd = 8'h00; m_rvld = 0; m_ovf = 0; m_udf = 0;
    end else if (clr) begin
      m_q.delete(); m_rvld = 0; m_ovf = 0; m_udf = 0;
    end else begin
      automatic bit was_full = m_q.size() == 16;
      automatic bit was_empty = m_q.size() == 0;
      m_rvld = 0;
      if (re) begin
        if (was_empty) m_udf = 1;
        else begin m_rd = m_q.pop_front(); m_rvld = 1; end
      end
      if (we) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(wd);
      end
    end
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge ck);
    if (chk_on) begin
      chk("cnt", cnt, m_q.size());
      chk("full", full, m_q.size() == 16);
      chk("empty", empty, m_q.size() == 0);
      chk("afull", afull, m_q.size() >= 14);
      chk("aempty", aempty, m_q.size() <= 2);
      chk("ovf", ovf, m_ovf);
      chk("udf", udf, m_udf);
      chk("rvld", rvld, m_rvld);
      chk("rd", rd, m_rd);
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    we = w; wd = d; re = r; clr = c;
    @(negedge ck);
  endtask

  initial begin
    #1 xar = 1'b0;
    repeat (2) @(negedge ck);
    xar = 1'b1;
    chk_on = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_rd", rd, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 12) chk("afull_13", afull, 0);
      if (i == 13) chk("afull_14", afull, 1);
    end
    chk("full_16", full, 1);
    chk("cnt_16", cnt, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1, 0);
      chk("burst_rvld", rvld, 1);
      chk("burst_rd", rd, i);
    end
    step(0, 8'h00, 0, 0);
    chk("burst_end_rvld", rvld, 0);
    chk("burst_end_empty", empty, 1);
    step(1, 8'h55, 1, 0);
    chk("udf_cnt", cnt, 1);
    chk("udf_flag", udf, 1);
    chk("udf_rvld", rvld, 0);
    step(0, 8'h00, 1, 0);
    chk("bypass_rd", rd, 8'h55);
    chk("bypass_rvld", rvld, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0);
    step(1, 8'hAA, 1, 0);
    chk("ovf_cnt", cnt, 15);
    chk("ovf_flag", ovf, 1);
    chk("ovf_rd", rd, 8'h10);
    for (int i = 0; i < 15; i++) begin
      step(0, 8'h00, 1, 0);
      chk("drain_rd", rd, 8'h11 + i);
      chk("no_aa", rd == 8'hAA, 0);
    end
    chk("sticky_udf", udf, 1);
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
    step(0, 8'h00, 0, 1);
    chk("clr0_cnt", cnt, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    chk("pre_clr_cnt", cnt, 7);
    chk("pre_clr_rd", rd, 8'h30);
    step(1, 8'h77, 1, 1);
    chk("clr_cnt", cnt, 0);
    chk("clr_rvld", rvld, 0);
    chk("clr_udf", udf, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_rd_hold", rd, 8'h30);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
    we = 0; re = 1;
    @(posedge ck);
    #2 xar = 1'b0;
    #1;
    chk("xar_empty", empty, 1);
    chk("xar_cnt", cnt, 0);
    chk("xar_rvld", rvld, 0);
    chk("xar_rd", rd, 0);
    @(negedge ck);
    re = 0;
    xar = 1'b1;
    step(0, 8'h00, 1, 0);
    chk("post_xar_rvld", rvld, 0);
    chk("post_xar_udf", udf, 1);
    step(0, 8'h00, 0, 0);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_fifo.md
SC_FIFO -- requirements
Module: sc_fifo

Interface
REQ-001 SHALL have parameter C_DAT_W, default 8, data width in bits.
REQ-002 SHALL have parameter C_ADR_W, default 4, address width; depth = 2**C_ADR_W entries.
REQ-003 SHALL have parameter C_AF_LVL, default 2**C_ADR_W-2; AFULL_o asserts when count >= C_AF_LVL.
REQ-004 SHALL have parameter C_AE_LVL, default 2; AEMPTY_o asserts when count <= C_AE_LVL.
REQ-005 SHALL have port CK_i, input, 1, the single clock, rising edge.
REQ-006 SHALL have port XAR_i, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port CLR_i, input, 1, synchronous flush, active-high.
REQ-008 SHALL have ports WE_i (input, 1) and WDs_i (input, C_DAT_W): write request and write data.
REQ-009 SHALL have port RE_i, input, 1, read request.
REQ-010 SHALL have ports RDs_o (output, C_DAT_W) and RVLD_o (output, 1): read data and its valid strobe.
REQ-011 SHALL have outputs FULL_o, EMPTY_o, AFULL_o and AEMPTY_o, each 1 bit.
REQ-012 SHALL have port CNTs_o, output, C_ADR_W+1, current occupancy, 0..2**C_ADR_W.
REQ-013 SHALL have outputs OVF_o and UDF_o, each 1 bit: sticky overflow and underflow flags.

Function
REQ-014 SHALL accept a write on the rising edge where WE_i=1 and FULL_o=0, storing WDs_i at the write pointer and advancing it by 1.
REQ-015 SHALL accept a read on the rising edge where RE_i=1 and EMPTY_o=0, advancing the read pointer by 1.
REQ-016 SHALL drive RDs_o with the accepted word, and RVLD_o=1 for exactly one cycle, on the edge after read acceptance (1-cycle latency); RDs_o holds its value otherwise.
REQ-017 SHALL wrap both pointers modulo 2**C_ADR_W with no gap or skipped entry.
REQ-018 SHALL keep CNTs_o registered: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-019 SHALL derive FULL_o = (count == 2**C_ADR_W), EMPTY_o = (count == 0), and AFULL_o/AEMPTY_o from the registered count, all updating on the same edge as CNTs_o.
REQ-020 SHALL ignore WE_i while FULL_o=1, even when RE_i=1 in the same cycle; memory and count are unchanged by the write, and OVF_o sets.
REQ-021 SHALL ignore RE_i while EMPTY_o=1, even when WE_i=1 in the same cycle (no write-to-read bypass); RVLD_o stays 0 and UDF_o sets.
REQ-022 SHALL hold OVF_o/UDF_o at 1 until reset or CLR_i.
REQ-023 SHALL give CLR_i priority over WE_i/RE_i: pointers, count, OVF_o, UDF_o and RVLD_o go to 0 on the next edge, and memory contents are not cleared.
REQ-024 SHALL produce no RVLD_o pulse on the edge after CLR_i, even if a read was accepted in the cycle before CLR_i.

Reset
REQ-025 SHALL on XAR_i=0 immediately clear pointers, count, RDs_o, RVLD_o, OVF_o and UDF_o, giving EMPTY_o=1, AEMPTY_o=1, FULL_o=0 and AFULL_o=0.
REQ-026 SHALL leave the storage array unreset.
REQ-027 SHALL, on reset asserted mid-transfer, discard any in-flight read and lose all queued data.

Structure
REQ-028 SHALL place the storage in sub-module sfifo_mem: 1 write port and 1 registered read port on CK_i, with parameters C_DAT_W and C_ADR_W, inferable as block RAM.
REQ-029 SHALL put the default widths and level constants in shared package chr_gen_pkg; pointer/count logic stays in sc_fifo.
REQ-030 SHALL elaborate with C_ADR_W=1..12 and C_DAT_W=1..64.

Verification (C_DAT_W=8, C_ADR_W=4 unless stated)
REQ-031 SHALL check: reset, then write 0x00..0x0F over 16 cycles -> FULL_o=1 and CNTs_o=16 after the 16th edge; AFULL_o=1 from count 14.
REQ-032 SHALL check: read 16 words back-to-back -> RDs_o=0x00..0x0F in order, RVLD_o high for 16 cycles starting 1 cycle after the first RE_i, then EMPTY_o=1.
REQ-033 SHALL check: at count=16 drive WE_i=RE_i=1 with data 0xAA -> count becomes 15, OVF_o=1, and 0xAA never appears at RDs_o.
REQ-034 SHALL check: at count=0 drive WE_i=RE_i=1 with data 0x55 -> count becomes 1, UDF_o=1, RVLD_o=0, and the next read returns 0x55.
REQ-035 SHALL check: 40 random interleaved writes/reads crossing the pointer wrap -> output order equals input order and CNTs_o matches a reference model every cycle.
REQ-036 SHALL check: CLR_i pulsed with count=7 and a read accepted in the prior cycle -> count=0, no RVLD_o pulse, flags cleared; XAR_i asserted mid-burst likewise gives EMPTY_o=1 asynchronously.
